// File: rtl/host_operand_loader_if.sv
// Host-side stream and result handshake of the operand loader.
interface host_operand_loader_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [DATA_W-1:0] in_data;
  logic              go;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ack;
  logic              timeout_err;

  modport master (
    output in_valid, in_kind, in_data, go, result_ack,
    input  in_ready, busy, result, result_valid, timeout_err
  );

  modport slave (
    input  in_valid, in_kind, in_data, go, result_ack,
    output in_ready, busy, result, result_valid, timeout_err
  );
endinterface

// File: rtl/host_operand_loader.sv
// Loads two operands and an opcode into memory words 0..2, runs the CPU,
// and returns memory word 3 (or all ones on timeout) to the host.
//
// state | meaning
// IDLE  | accept host words, wait for go with all three kinds loaded
// W1    | write strobe for word 0 (numberOne)
// W2    | write strobe for word 1 (numberTwo)
// WOP   | write strobe for word 2 (operation)
// START | one-cycle CPU release, clear timeout counter
// WAIT  | wait for cpu_done or timeout
// READ  | result-read strobe, capture word 3
// DONE  | result valid until acknowledged
module host_operand_loader #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  host_operand_loader_if.slave host,
  output logic                 cpu_start,
  input  logic                 cpu_done,
  output logic                 mem_wd_NumberOne,
  output logic [DATA_W-1:0]    numberOne,
  output logic                 mem_wd_NumberTwo,
  output logic [DATA_W-1:0]    numberTwo,
  output logic                 mem_wd_Operation,
  output logic [DATA_W-1:0]    operation,
  output logic                 mem_rd_Result,
  input  logic [DATA_W-1:0]    result_output
);

  typedef enum logic [2:0] {
    S_IDLE, S_W1, S_W2, S_WOP, S_START, S_WAIT, S_READ, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              f1, f2, fop;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] result_q;
  logic              timeout_err_q;
  logic              wait_expired;

  assign wait_expired      = (cnt == CNT_TERM);
  assign host.in_ready     = (state == S_IDLE);
  assign host.busy         = (state != S_IDLE);
  assign host.result_valid = (state == S_DONE);
  assign host.result       = result_q;
  assign host.timeout_err  = timeout_err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (host.go && f1 && f2 && fop && !host.in_valid) state_nxt = S_W1;
      S_W1:    state_nxt = S_W2;
      S_W2:    state_nxt = S_WOP;
      S_WOP:   state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cpu_done)          state_nxt = S_READ;
        else if (wait_expired) state_nxt = S_DONE;
      end
      S_READ:  state_nxt = S_DONE;
      S_DONE:  if (host.result_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      mem_wd_NumberOne <= 1'b0;
      mem_wd_NumberTwo <= 1'b0;
      mem_wd_Operation <= 1'b0;
      cpu_start        <= 1'b0;
      mem_rd_Result    <= 1'b0;
      numberOne        <= '0;
      numberTwo        <= '0;
      operation        <= '0;
      f1               <= 1'b0;
      f2               <= 1'b0;
      fop              <= 1'b0;
      cnt              <= '0;
      result_q         <= '0;
      timeout_err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      // Strobes are decoded from the next state so they are flops aligned with their state.
      mem_wd_NumberOne <= (state_nxt == S_W1);
      mem_wd_NumberTwo <= (state_nxt == S_W2);
      mem_wd_Operation <= (state_nxt == S_WOP);
      cpu_start        <= (state_nxt == S_START);
      mem_rd_Result    <= (state_nxt == S_READ);

      if (state == S_IDLE && host.in_valid) begin
        case (host.in_kind)
          2'b00: begin numberOne <= host.in_data; f1  <= 1'b1; end
          2'b01: begin numberTwo <= host.in_data; f2  <= 1'b1; end
          2'b10: begin operation <= host.in_data; fop <= 1'b1; end
          default: ;
        endcase
      end

      if (state == S_START)     cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + 1'b1;

      if (state == S_WAIT && !cpu_done && wait_expired) begin
        timeout_err_q <= 1'b1;
        result_q      <= '1;
      end else if (state == S_READ) begin
        timeout_err_q <= 1'b0;
        result_q      <= result_output;
      end
    end
  end

endmodule

// File: doc/host_operand_loader.md
Name: host_operand_loader

Overview:
- Host-side sequencer directly upstream of the unified instruction/data memory.
- Collects two operands and an operation code from a simple valid/ready host stream, then writes them into memory words 0, 1 and 2 using the memory's dedicated write strobes.
- Then pulses the CPU start, waits for completion, reads word 3 through the result-read strobe, and holds the result for the host until it is acknowledged.

Parameters:
- DATA_W, 32, width of operands, operation and result.
- TIMEOUT, 1000, maximum WAIT cycles before the run is aborted (≥1).
- CNT_W, 16, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  host word valid.
- in_ready  output  1  loader can accept a host word.
- in_kind  input  2  00 = numberOne, 01 = numberTwo, 10 = operation, 11 = ignored.
- in_data  input  DATA_W  host word.
- go  input  1  request a run.
- busy  output  1  high in every state except IDLE.
- cpu_start  output  1  one-cycle CPU release pulse.
- cpu_done  input  1  CPU finished; level or pulse.
- mem_wd_NumberOne  output  1  write strobe for memory word 0.
- numberOne  output  DATA_W  operand 1 holding register.
- mem_wd_NumberTwo  output  1  write strobe for memory word 1.
- numberTwo  output  DATA_W  operand 2 holding register.
- mem_wd_Operation  output  1  write strobe for memory word 2.
- operation  output  DATA_W  operation holding register.
- mem_rd_Result  output  1  result-read strobe for memory word 3.
- result_output  input  DATA_W  memory result word, combinational from the memory.
- result  output  DATA_W  captured result.
- result_valid  output  1  result available to the host.
- result_ack  input  1  host consumed the result.
- timeout_err  output  1  last run timed out.

Behaviour:
- **Reset** (synchronous): state IDLE. All strobes, cpu_start, busy, result_valid and timeout_err are 0. result, numberOne, numberTwo and operation are 0. Loaded-flags f1/f2/fop are cleared. Timeout counter is 0. Reset asserted in any state takes effect on that edge.
- **Host interface**:
  - in_ready = 1 only in IDLE.
  - A transfer occurs when in_valid && in_ready. The word is registered into the holding register selected by in_kind, and the matching flag is set.
  - Reloading a kind overwrites its register. in_kind = 11 is accepted and discarded.
  - Flags and holding registers persist across runs; only reset clears them.
- **State machine**, one transition per clock:
  - IDLE: if go && f1 && f2 && fop && !in_valid, go to W1. Otherwise go is ignored (no queuing). A host transfer in the same cycle as go wins, and go is dropped.
  - W1: mem_wd_NumberOne = 1, then W2.
  - W2: mem_wd_NumberTwo = 1, then WOP.
  - WOP: mem_wd_Operation = 1, then START.
  - START: cpu_start = 1, counter cleared, then WAIT.
  - WAIT:
    - Counter increments each cycle.
    - If cpu_done, go to READ; cpu_done has priority over timeout when both occur in the same cycle.
    - Else if counter == TIMEOUT-1, set timeout_err, set result = all ones, and go to DONE.
    - cpu_done seen outside WAIT is ignored.
  - READ: mem_rd_Result = 1. result <= result_output on this edge; timeout_err <= 0. Then DONE.
  - DONE: result_valid = 1. When result_ack, go to IDLE. result and timeout_err are held until the next run completes.
- **Outputs**: strobes and cpu_start are registered Moore outputs, each exactly one cycle wide, and never asserted simultaneously. numberOne/numberTwo/operation are stable throughout W1–WOP.
- **Latency**: go accepted to cpu_start is 4 cycles. cpu_done to result_valid is 2 cycles.

Test Plan:
- Load 18 (kind 00), 7 (kind 01), 32'h20 (kind 10), then go; CPU model asserts cpu_done 20 cycles after cpu_start; memory returns 25 → W1/W2/WOP strobes on consecutive cycles with the correct data, one cpu_start pulse, result = 25, result_valid held until result_ack, then IDLE.
- go with only numberOne and operation loaded → no strobes, busy stays 0; after loading numberTwo, go starts a run normally.
- go and in_valid in the same cycle (kind 01, value 9) → numberTwo = 9, run not started; go on the next cycle starts the run.
- TIMEOUT = 8, cpu_done never asserted → timeout_err = 1, result = 32'hFFFFFFFF, mem_rd_Result never asserted; the next successful run clears timeout_err.
- Reset asserted in WAIT → next cycle IDLE, all outputs 0, flags cleared; go is ignored until all three kinds are reloaded.
- Back-to-back runs reloading only operation (32'h22) → second run rewrites all three words with the retained operands and the new operation, and returns the new result.
